// File: rtl/demux_1_2_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants for the 1-to-2 steering block: route select
//                encodings, default data width and event counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   // Route select values carried on Op
   localparam logic DEMUX_SEL_OUT0 = 1'b0;
   localparam logic DEMUX_SEL_OUT1 = 1'b1;

   // Default data width of the producer and both consumer streams
   localparam int DEMUX_DATA_W = 32;

   // Width of the optional per-slot drain counters
   localparam int DEMUX_CNT_W = 16;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/demux_1_2_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1_2_pipe_if
//  Description : Producer stream plus two consumer streams of the 1-to-2
//                steering block. The master modport is the environment side
//                (producer and both sinks); the slave modport is the block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface demux_1_2_pipe_if
   import cpu_pkg::*;
#(
   parameter int W = DEMUX_DATA_W
);

   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic         Op;
   logic [W-1:0] out0_data;
   logic         out0_valid;
   logic         out0_ready;
   logic [W-1:0] out1_data;
   logic         out1_valid;
   logic         out1_ready;

   modport master (
      output in_data, in_valid, Op, out0_ready, out1_ready,
      input  in_ready, out0_data, out0_valid, out1_data, out1_valid
   );

   modport slave (
      input  in_data, in_valid, Op, out0_ready, out1_ready,
      output in_ready, out0_data, out0_valid, out1_data, out1_valid
   );

endinterface : demux_1_2_pipe_if
`default_nettype wire

// File: rtl/demux_1_2_pipe_out_slot.sv
`default_nettype none
// ============================================================================
//  Module      : demux_out_slot
//  Description : One-entry output holding slot. Accepts a word on load, offers
//                it downstream until the sink takes it, and reports whether a
//                new word can be taken this cycle (free). A load in the same
//                cycle as a drain replaces the word, giving full throughput.
//                Optional drain counter enabled by macro DEMUX_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_out_slot
   import cpu_pkg::*;
#(
   parameter int W = DEMUX_DATA_W
) (
   input  wire logic                   clk,
   input  wire logic                   rst,
   input  wire logic                   load,
   input  wire logic [W-1:0]           load_data,
   input  wire logic                   out_ready,
   output logic                        out_valid,
   output logic [W-1:0]                out_data,
   output logic                        free
`ifdef DEMUX_COUNT_EN
   ,
   output logic [DEMUX_CNT_W-1:0]      cnt
`endif
);

   logic          r_full;
   logic [W-1:0]  r_data;
   logic          w_drain;

   assign w_drain   = r_full & out_ready;
   assign free      = ~r_full | out_ready;
   assign out_valid = r_full;
   assign out_data  = r_data;

   // Slot occupancy and payload; a load wins over a drain so the slot stays full
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (load) begin
         r_full <= 1'b1;
         r_data <= load_data;
      end else if (w_drain) begin
         r_full <= 1'b0;
      end
   end

`ifdef DEMUX_COUNT_EN
   logic [DEMUX_CNT_W-1:0] r_cnt;

   assign cnt = r_cnt;

   // Count words handed to the sink; wraps naturally at full scale
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_drain) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
`endif

endmodule : demux_out_slot
`default_nettype wire

// File: rtl/demux_1_2_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1_2_pipe
//  Description : Registered 1-to-2 steering block. Each word from the producer
//                is routed by Op into one of two independent one-entry slots,
//                so a stalled sink only blocks words addressed to it.
//                in_ready is combinational from Op and the selected sink's
//                ready; this path is intentional.
//                Optional drain counters cnt0/cnt1 enabled by DEMUX_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_1_2_pipe
   import cpu_pkg::*;
#(
   parameter int W = DEMUX_DATA_W
) (
   input  wire logic                   clk,
   input  wire logic                   rst,
   demux_1_2_pipe_if.slave             bus
`ifdef DEMUX_COUNT_EN
   ,
   output logic [DEMUX_CNT_W-1:0]      cnt0,
   output logic [DEMUX_CNT_W-1:0]      cnt1
`endif
);

   logic w_free0;
   logic w_free1;
   logic w_accept;
   logic w_load0;
   logic w_load1;

   // Ready follows whichever slot the current Op points at
   assign bus.in_ready = (bus.Op == DEMUX_SEL_OUT1) ? w_free1 : w_free0;
   assign w_accept     = bus.in_valid & bus.in_ready;
   assign w_load0      = w_accept & (bus.Op == DEMUX_SEL_OUT0);
   assign w_load1      = w_accept & (bus.Op == DEMUX_SEL_OUT1);

   demux_out_slot #(
      .W          (W)
   ) u_slot0 (
      .clk        (clk),
      .rst        (rst),
      .load       (w_load0),
      .load_data  (bus.in_data),
      .out_ready  (bus.out0_ready),
      .out_valid  (bus.out0_valid),
      .out_data   (bus.out0_data),
      .free       (w_free0)
`ifdef DEMUX_COUNT_EN
      ,
      .cnt        (cnt0)
`endif
   );

   demux_out_slot #(
      .W          (W)
   ) u_slot1 (
      .clk        (clk),
      .rst        (rst),
      .load       (w_load1),
      .load_data  (bus.in_data),
      .out_ready  (bus.out1_ready),
      .out_valid  (bus.out1_valid),
      .out_data   (bus.out1_data),
      .free       (w_free1)
`ifdef DEMUX_COUNT_EN
      ,
      .cnt        (cnt1)
`endif
   );

endmodule : demux_1_2_pipe
`default_nettype wire

// File: tb/tb_demux_1_2_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_1_2_pipe
//  Description : Self-checking bench for demux_1_2_pipe: directed vector table,
//                hand-written corner sequences and a randomized run against a
//                queue-based reference model. Counter checks follow
//                DEMUX_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1_2_pipe;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests  = 0;
   int   failed = 0;

   always #5 clk = ~clk;

   demux_1_2_pipe_if #(.W(32)) bus ();

`ifdef DEMUX_COUNT_EN
   logic [15:0] cnt0;
   logic [15:0] cnt1;
`endif

   demux_1_2_pipe #(
      .W    (32)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus)
`ifdef DEMUX_COUNT_EN
      ,
      .cnt0 (cnt0),
      .cnt1 (cnt1)
`endif
   );

   typedef struct {
      logic        v;
      logic        op;
      logic [31:0] d;
      logic        r0;
      logic        r1;
      logic        exp_rdy;
      logic        exp_v0;
      logic [31:0] exp_d0;
      logic        exp_v1;
      logic [31:0] exp_d1;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic op, input logic [31:0] d,
                        input logic r0, input logic r1);
      bus.in_valid   = v;
      bus.Op         = op;
      bus.in_data    = d;
      bus.out0_ready = r0;
      bus.out1_ready = r1;
   endtask

   // Called on a falling edge; leaves the block empty and returns on a falling edge
   task automatic do_reset();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] q0[$];
      logic [31:0] q1[$];
      logic        rv, rop, rr0, rr1, erdy;
      logic [31:0] rd;
      int          seen1;
      int          drains0, drains1;

      // ---------------- reset state ----------------
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_out0_valid", {31'b0, bus.out0_valid}, 32'h0);
      check("rst_out1_valid", {31'b0, bus.out1_valid}, 32'h0);
      check("rst_out0_data", bus.out0_data, 32'h0);
      check("rst_out1_data", bus.out1_data, 32'h0);
      check("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
`ifdef DEMUX_COUNT_EN
      check("rst_cnt0", {16'b0, cnt0}, 32'h0);
      check("rst_cnt1", {16'b0, cnt1}, 32'h0);
`endif
      rst = 1'b0;

      // ---------------- directed vector table ----------------
      tbl[0] = '{1'b1, 1'b0, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0, 32'h0};
      tbl[1] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h12345678, 1'b0, 32'h0};
      tbl[2] = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 1'b1, 32'hDEADBEEF};
      tbl[3] = '{1'b1, 1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b1, 32'hDEADBEEF};
      tbl[4] = '{1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 1'b1, 32'hDEADBEEF};
      tbl[5] = '{1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000002, 1'b1, 32'hDEADBEEF};
      tbl[6] = '{1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000002, 1'b0, 32'hDEADBEEF};
      tbl[7] = '{1'b1, 1'b0, 32'h00000055, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000055, 1'b0, 32'hDEADBEEF};

      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].v, tbl[i].op, tbl[i].d, tbl[i].r0, tbl[i].r1);
         #1;
         check($sformatf("tbl%0d_in_ready", i), {31'b0, bus.in_ready}, {31'b0, tbl[i].exp_rdy});
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_out0_valid", i), {31'b0, bus.out0_valid}, {31'b0, tbl[i].exp_v0});
         check($sformatf("tbl%0d_out0_data", i), bus.out0_data, tbl[i].exp_d0);
         check($sformatf("tbl%0d_out1_valid", i), {31'b0, bus.out1_valid}, {31'b0, tbl[i].exp_v1});
         check($sformatf("tbl%0d_out1_data", i), bus.out1_data, tbl[i].exp_d1);
         @(negedge clk);
      end

      // ---------------- reset mid-transfer ----------------
      do_reset();
      drive(1'b1, 1'b0, 32'hAAAA0000, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b1, 1'b1, 32'h5555FFFF, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("mid_pre_out0", bus.out0_data, 32'hAAAA0000);
      check("mid_pre_out1", bus.out1_data, 32'h5555FFFF);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_out0_valid", {31'b0, bus.out0_valid}, 32'h0);
      check("mid_rst_out1_valid", {31'b0, bus.out1_valid}, 32'h0);
      check("mid_rst_out0_data", bus.out0_data, 32'h0);
      check("mid_rst_out1_data", bus.out1_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 1'b0, 32'h0BADF00D, 1'b0, 1'b0);
      #1;
      check("mid_release_in_ready", {31'b0, bus.in_ready}, 32'h1);
      @(negedge clk);

      // ---------------- back-to-back streaming on out1 ----------------
      do_reset();
      for (int w = 1; w <= 8; w++) begin
         drive(1'b1, 1'b1, 32'(w), 1'b0, 1'b1);
         #1;
         check($sformatf("stream%0d_in_ready", w), {31'b0, bus.in_ready}, 32'h1);
         @(posedge clk);
         #1;
         check($sformatf("stream%0d_out1_valid", w), {31'b0, bus.out1_valid}, 32'h1);
         check($sformatf("stream%0d_out1_data", w), bus.out1_data, 32'(w));
         @(negedge clk);
      end
      check("stream_out0_valid", {31'b0, bus.out0_valid}, 32'h0);

      // ---------------- simultaneous load and drain on slot 0 ----------------
      do_reset();
      seen1 = 0;
      drive(1'b1, 1'b0, 32'h1, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h2, 1'b1, 1'b0);
      #1;
      check("ld_dr_in_ready", {31'b0, bus.in_ready}, 32'h1);
      if (bus.out0_valid && bus.out0_ready && bus.out0_data == 32'h1) seen1++;
      @(posedge clk);
      #1;
      check("ld_dr_out0_valid", {31'b0, bus.out0_valid}, 32'h1);
      check("ld_dr_out0_data", bus.out0_data, 32'h2);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      if (bus.out0_valid && bus.out0_ready && bus.out0_data == 32'h1) seen1++;
      @(posedge clk);
      #1;
      check("ld_dr_seen1_once", 32'(seen1), 32'h1);
      check("ld_dr_out0_drained", {31'b0, bus.out0_valid}, 32'h0);
      @(negedge clk);

      // ---------------- randomized run against queue model ----------------
      do_reset();
      drains0 = 0;
      drains1 = 0;
      for (int n = 0; n < 400; n++) begin
         rv  = ($urandom_range(0, 3) != 0);
         rop = 1'($urandom_range(0, 1));
         rd  = $urandom();
         rr0 = ($urandom_range(0, 2) != 0);
         rr1 = ($urandom_range(0, 2) != 0);
         drive(rv, rop, rd, rr0, rr1);
         #1;
         erdy = rop ? (q1.size() == 0 || rr1) : (q0.size() == 0 || rr0);
         check("rnd_in_ready", {31'b0, bus.in_ready}, {31'b0, erdy});
         check("rnd_out0_valid", {31'b0, bus.out0_valid}, {31'b0, (q0.size() != 0)});
         check("rnd_out1_valid", {31'b0, bus.out1_valid}, {31'b0, (q1.size() != 0)});
         if (q0.size() != 0) check("rnd_out0_data", bus.out0_data, q0[0]);
         if (q1.size() != 0) check("rnd_out1_data", bus.out1_data, q1[0]);
         if (q0.size() != 0 && rr0) begin
            void'(q0.pop_front());
            drains0++;
         end
         if (q1.size() != 0 && rr1) begin
            void'(q1.pop_front());
            drains1++;
         end
         if (rv && erdy) begin
            if (rop) q1.push_back(rd);
            else     q0.push_back(rd);
         end
         @(posedge clk);
         @(negedge clk);
      end
`ifdef DEMUX_COUNT_EN
      check("rnd_cnt0", {16'b0, cnt0}, {16'b0, 16'(drains0)});
      check("rnd_cnt1", {16'b0, cnt1}, {16'b0, 16'(drains1)});

      // ---------------- counter wrap on out0 ----------------
      do_reset();
      drive(1'b1, 1'b0, 32'h77, 1'b1, 1'b0);
      repeat (65536) @(posedge clk);
      #1;
      check("wrap_cnt0_ffff", {16'b0, cnt0}, 32'h0000FFFF);
      @(posedge clk);
      #1;
      check("wrap_cnt0_zero", {16'b0, cnt0}, 32'h0);
      check("wrap_cnt1_zero", {16'b0, cnt1}, 32'h0);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule : tb_demux_1_2_pipe
`default_nettype wire
